rf_cmd_sequencer: RTL and testbench
===================================

Name: rf_cmd_sequencer

Overview:
- Command-driven initiator for the 8x16 register file: accepts one register-transfer command at a time and drives the file's writenum/readnum/write/data_in ports.
- Consumes the file's registered data_out.
- Sits between the instruction controller and the register file. Performs MOVI, MOV, ADD and CMP using the file's one-cycle registered read, which only updates when write=0.

Parameters:
- DATA_W, 16, datapath and register width.
- REG_AW, 3, register index width (2**REG_AW registers).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 MOVI, 01 MOV, 10 ADD, 11 CMP.
- cmd_rd  input  REG_AW  destination register.
- cmd_rn  input  REG_AW  first source (ADD/CMP).
- cmd_rm  input  REG_AW  second source (MOV/ADD/CMP).
- cmd_imm  input  DATA_W  immediate (MOVI).
- rf_writenum  output  REG_AW  to register file writenum.
- rf_readnum  output  REG_AW  to register file readnum.
- rf_write  output  1  to register file write.
- rf_data_in  output  DATA_W  to register file data_in.
- rf_data_out  input  DATA_W  from register file data_out (valid 1 cycle after readnum is presented with write=0).
- done  output  1  one-cycle pulse when a command completes.
- result  output  DATA_W  last computed value (held).
- flag_z, flag_n, flag_v  output  1 each  status from the last ADD/CMP (held).

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- States: IDLE, RD1, RD2, EXEC, WB, DONE. Reset forces IDLE and clears all internal registers.
- Output values in reset: cmd_ready=0, rf_write=0, rf_writenum=0, rf_readnum=0, rf_data_in=0, done=0, result=0, flags=0.
- Port outputs are decoded from state. cmd_ready = (state==IDLE) && !reset.
- Accept: at the edge where cmd_valid && cmd_ready, latch op, rd, rn, rm.
  - MOVI: result_q <= cmd_imm; next state WB.
  - Any other op: next state RD1.
- cmd_valid outside IDLE is ignored. No queuing.
- RD1: rf_readnum=rm, rf_write=0.
- RD2: rf_readnum=rn, rf_write=0. At the end of the cycle, a_q <= rf_data_out (= R[rm]).
- EXEC: rf_readnum=rn, rf_write=0. rf_data_out holds R[rn]. At the end of the cycle:
  - MOV: result_q <= a_q.
  - ADD: result_q <= R[rn]+a_q.
  - CMP: result_q <= R[rn]-a_q.
  - ADD/CMP update flags: z = (value==0); n = value MSB; v = signed overflow.
  - MOV leaves flags unchanged.
  - Next state: CMP goes to DONE; all others go to WB.
- WB: rf_write=1, rf_writenum=rd, rf_data_in=result_q. rf_readnum is held at its previous value. Next state DONE.
- DONE: done=1, cmd_ready=0. Next state IDLE.
- Outside WB: rf_write=0 and rf_data_in=0.
- Latency from the accept edge (cycle T = first cycle after accept):
  - MOVI: WB at T, done at T+1.
  - MOV/ADD: WB at T+3, done at T+4.
  - CMP: done at T+3.
  - Minimum command-to-command spacing is done cycle + 1 (IDLE).
- Arithmetic is modulo 2**DATA_W. Carry is dropped.
- rd==rn==rm is legal. Reads complete before WB, so ADD R1,R1,R1 doubles R1.
- reset mid-command: next state IDLE, command is discarded. No rf_write in the cycle after the reset edge. Register file contents are not reset.
- result and flags hold until overwritten by a later command.

Optional Feature:
- Macro RF_CMD_SHIFT_EN.
- When defined:
  - Input port cmd_shift [1:0] is added and latched at accept.
  - The shift is applied to a_q (the Rm operand) in EXEC before the MOV/ADD/CMP operation: 00 none, 01 LSL1 (LSB 0), 10 LSR1 (MSB 0), 11 ASR1 (MSB replicated).
- When undefined: the port is absent and the behaviour equals shift 00.

Test Plan:
- MOVI R3,0x1234: WB cycle has rf_write=1, writenum=3, data_in=0x1234; done 1 cycle later; result=0x1234; cmd_ready low from accept+1 to done.
- MOVI R1,5; MOVI R2,7; ADD R0,R1,R2 (rn=1, rm=2): readnum shows 2 in RD1 then 1 in RD2; WB writes 0x000C to R0 at accept+4; flag_z=0, flag_n=0, flag_v=0.
- MOVI R4,0x7FFF; MOVI R5,1; CMP rn=5, rm=4: result=0x8002, flag_n=1, flag_v=0, flag_z=0; no rf_write pulse in the whole command. Then MOVI R6,0x8000; CMP rn=6, rm=5: result=0x7FFF, flag_v=1, flag_n=0.
- MOVI R1,0x0003; ADD R1,R1,R1: R1=0x0006. Then MOV R7,R1: WB writes 0x0006 to R7; flags unchanged.
- Assert reset during EXEC of an ADD: next cycle state is IDLE, rf_write=0 throughout, done never pulses for the aborted command; cmd_ready=1 on the first cycle after reset deasserts.
- (RF_CMD_SHIFT_EN) R2=0x8001; MOV R3,R2 with shift 11: R3=0xC000. With shift 01: R3=0x0002.

Source files
------------

// File: rtl/rf_cmd_sequencer.sv
// Register-transfer command sequencer driving an 8x16 register file with a registered read port.
// Optional operand shifter on the Rm path is enabled by defining RF_CMD_SHIFT_EN.
module rf_cmd_sequencer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rn,
    input  logic [REG_AW-1:0] cmd_rm,
    input  logic [DATA_W-1:0] cmd_imm,
`ifdef RF_CMD_SHIFT_EN
    input  logic [1:0]        cmd_shift,
`endif
    output logic [REG_AW-1:0] rf_writenum,
    output logic [REG_AW-1:0] rf_readnum,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
);

    localparam int MSB = DATA_W - 1;
    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [REG_AW-1:0]  rn_q, rn_d;
    logic [REG_AW-1:0]  rm_q, rm_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic               v_q, v_d;
    logic [REG_AW-1:0]  readnum_hold_q, readnum_hold_d;
`ifdef RF_CMD_SHIFT_EN
    logic [1:0]         shift_q, shift_d;
`endif

    logic               accept;
    logic [DATA_W-1:0]  a_sh;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic               v_add;
    logic               v_sub;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = (cmd_op == OP_MOVI) ? S_WB : S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_EXEC;
            S_EXEC:  state_d = (op_q == OP_CMP) ? S_DONE : S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs: decoded from state, forced to zero while reset is asserted
    always_comb begin
        cmd_ready   = 1'b0;
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_readnum  = '0;
        rf_data_in  = '0;
        done        = 1'b0;
        if (!reset) begin
            rf_readnum = readnum_hold_q;
            case (state_q)
                S_IDLE: cmd_ready = 1'b1;
                S_RD1:  rf_readnum = rm_q;
                S_RD2:  rf_readnum = rn_q;
                S_EXEC: rf_readnum = rn_q;
                S_WB: begin
                    rf_write    = 1'b1;
                    rf_writenum = rd_q;
                    rf_data_in  = result_q;
                end
                S_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_v = v_q;

    assign accept = cmd_valid && cmd_ready;

`ifdef RF_CMD_SHIFT_EN
    always_comb begin
        case (shift_q)
            2'b01:   a_sh = {a_q[MSB-1:0], 1'b0};
            2'b10:   a_sh = {1'b0, a_q[MSB:1]};
            2'b11:   a_sh = {a_q[MSB], a_q[MSB:1]};
            default: a_sh = a_q;
        endcase
    end
`else
    assign a_sh = a_q;
`endif

    // In EXEC rf_data_out carries R[rn]; a_sh carries the (shifted) R[rm]
    assign sum   = rf_data_out + a_sh;
    assign diff  = rf_data_out - a_sh;
    assign v_add = (rf_data_out[MSB] == a_sh[MSB]) && (sum[MSB] != rf_data_out[MSB]);
    assign v_sub = (rf_data_out[MSB] != a_sh[MSB]) && (diff[MSB] != rf_data_out[MSB]);

    always_comb begin
        op_d           = op_q;
        rd_d           = rd_q;
        rn_d           = rn_q;
        rm_d           = rm_q;
        a_d            = a_q;
        result_d       = result_q;
        z_d            = z_q;
        n_d            = n_q;
        v_d            = v_q;
        readnum_hold_d = rf_readnum;
`ifdef RF_CMD_SHIFT_EN
        shift_d        = shift_q;
`endif
        if (accept) begin
            op_d = cmd_op;
            rd_d = cmd_rd;
            rn_d = cmd_rn;
            rm_d = cmd_rm;
`ifdef RF_CMD_SHIFT_EN
            shift_d = cmd_shift;
`endif
            if (cmd_op == OP_MOVI) result_d = cmd_imm;
        end
        if (state_q == S_RD2) a_d = rf_data_out;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_MOV: result_d = a_sh;
                OP_ADD: begin
                    result_d = sum;
                    z_d      = (sum == '0);
                    n_d      = sum[MSB];
                    v_d      = v_add;
                end
                OP_CMP: begin
                    result_d = diff;
                    z_d      = (diff == '0);
                    n_d      = diff[MSB];
                    v_d      = v_sub;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q           <= '0;
            rd_q           <= '0;
            rn_q           <= '0;
            rm_q           <= '0;
            a_q            <= '0;
            result_q       <= '0;
            z_q            <= 1'b0;
            n_q            <= 1'b0;
            v_q            <= 1'b0;
            readnum_hold_q <= '0;
`ifdef RF_CMD_SHIFT_EN
            shift_q        <= '0;
`endif
        end else begin
            op_q           <= op_d;
            rd_q           <= rd_d;
            rn_q           <= rn_d;
            rm_q           <= rm_d;
            a_q            <= a_d;
            result_q       <= result_d;
            z_q            <= z_d;
            n_q            <= n_d;
            v_q            <= v_d;
            readnum_hold_q <= readnum_hold_d;
`ifdef RF_CMD_SHIFT_EN
            shift_q        <= shift_d;
`endif
        end
    end

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Self-checking bench for rf_cmd_sequencer: attached register file plus an arithmetic reference model.
// Honours RF_CMD_SHIFT_EN in the same way as the design.
module tb_rf_cmd_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [15:0] cmd_imm;
`ifdef RF_CMD_SHIFT_EN
    logic [1:0]  cmd_shift;
`endif
    logic [2:0]  rf_writenum, rf_readnum;
    logic        rf_write;
    logic [15:0] rf_data_in, rf_data_out;
    logic        done;
    logic [15:0] result;
    logic        flag_z, flag_n, flag_v;

    rf_cmd_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rn     (cmd_rn),
        .cmd_rm     (cmd_rm),
        .cmd_imm    (cmd_imm),
`ifdef RF_CMD_SHIFT_EN
        .cmd_shift  (cmd_shift),
`endif
        .rf_writenum(rf_writenum),
        .rf_readnum (rf_readnum),
        .rf_write   (rf_write),
        .rf_data_in (rf_data_in),
        .rf_data_out(rf_data_out),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v)
    );

    // 8x16 register file: write on the edge, read registered and only when not writing
    logic [15:0] rf_mem [8];
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
        else          rf_data_out <= rf_mem[rf_readnum];
    end

    logic [15:0] m_regs [8];
    logic [15:0] m_result;
    logic        m_z, m_n, m_v;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] shift_op(input logic [15:0] x, input logic [1:0] sh);
        case (sh)
            2'd1:    return 16'(x * 2);
            2'd2:    return x / 2;
            2'd3:    return 16'($signed(x) >>> 1);
            default: return x;
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [15:0] imm, input logic [1:0] sh);
        int          a, b, val, cyc, nwr, wcyc, exp_lat;
        logic [15:0] exp_val, sa, wdat, old_rd;
        logic [2:0]  wnum, rn0, rn1;
        bit          do_wr;

        sa      = shift_op(m_regs[rm], sh);
        a       = int'($signed(sa));
        b       = int'($signed(m_regs[rn]));
        do_wr   = 1'b1;
        exp_lat = 4;
        old_rd  = m_regs[rd];
        case (op)
            2'd0: begin exp_val = imm; exp_lat = 1; end
            2'd1: exp_val = sa;
            2'd2: begin
                val = b + a; exp_val = 16'(val);
                m_z = (exp_val == 16'd0); m_n = exp_val[15];
                m_v = (val > 32767) || (val < -32768);
            end
            default: begin
                val = b - a; exp_val = 16'(val);
                m_z = (exp_val == 16'd0); m_n = exp_val[15];
                m_v = (val > 32767) || (val < -32768);
                do_wr = 1'b0; exp_lat = 3;
            end
        endcase
        m_result = exp_val;

        @(negedge clk);
        check_val("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
`ifdef RF_CMD_SHIFT_EN
        cmd_shift = sh;
`endif
        @(negedge clk);
        cyc = 0; nwr = 0; wcyc = -1; wnum = '0; wdat = '0; rn0 = '0; rn1 = '0;
        while (done !== 1'b1 && cyc < 12) begin
            // garbage commands while busy must be ignored
            cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_rd = 3'($urandom);
            cmd_rn = 3'($urandom); cmd_rm = 3'($urandom); cmd_imm = 16'($urandom);
            if (rf_write === 1'b1) begin nwr++; wnum = rf_writenum; wdat = rf_data_in; wcyc = cyc; end
            if (cyc == 0) rn0 = rf_readnum;
            if (cyc == 1) rn1 = rf_readnum;
            check_val("ready_busy", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check_val("latency", cyc, exp_lat);
        check_val("ready_done", {31'd0, cmd_ready}, 32'd0);
        check_val("wr_in_done", {31'd0, rf_write}, 32'd0);
        check_val("result", {16'd0, result}, {16'd0, m_result});
        check_val("flags", {29'd0, flag_z, flag_n, flag_v}, {29'd0, m_z, m_n, m_v});
        check_val("n_writes", nwr, do_wr ? 1 : 0);
        if (do_wr) begin
            check_val("wr_num", {29'd0, wnum}, {29'd0, rd});
            check_val("wr_data", {16'd0, wdat}, {16'd0, exp_val});
            check_val("wr_cycle", wcyc, exp_lat - 1);
            m_regs[rd] = exp_val;
        end
        if (op != 2'd0) begin
            check_val("readnum_rd1", {29'd0, rn0}, {29'd0, rm});
            check_val("readnum_rd2", {29'd0, rn1}, {29'd0, rn});
        end
        check_val("rf_content", {16'd0, rf_mem[rd]}, {16'd0, do_wr ? exp_val : old_rd});
        $display("cmd op=%0d rd=%0d rn=%0d rm=%0d imm=%04h sh=%0d -> result=%04h znv=%0d%0d%0d lat=%0d",
                 op, rd, rn, rm, imm, sh, result, flag_z, flag_n, flag_v, cyc);
    endtask

    task automatic reset_mid_add(input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
        int          bad;
        logic [15:0] old_rd;
        old_rd = m_regs[rd];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = 16'h0;
`ifdef RF_CMD_SHIFT_EN
        cmd_shift = 2'd0;
`endif
        bad = 0;
        @(negedge clk); cmd_valid = 1'b0;                 // RD1
        if (rf_write !== 1'b0 || done !== 1'b0) bad++;
        @(negedge clk);                                    // RD2
        if (rf_write !== 1'b0 || done !== 1'b0) bad++;
        @(negedge clk);                                    // EXEC
        if (rf_write !== 1'b0 || done !== 1'b0) bad++;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_wr", {31'd0, rf_write}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        m_result = 16'd0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (rf_write !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check_val("abort_quiet", bad, 0);
        check_val("abort_result", {16'd0, result}, {16'd0, m_result});
        check_val("abort_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        check_val("abort_rf", {16'd0, rf_mem[rd]}, {16'd0, old_rd});
        $display("reset during ADD rd=%0d rn=%0d rm=%0d -> aborted, result=%04h", rd, rn, rm, result);
    endtask

    initial begin
        logic [1:0] sh;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
`ifdef RF_CMD_SHIFT_EN
        cmd_shift = '0;
`endif
        m_result = '0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {cmd_ready, rf_write, rf_writenum, rf_readnum, rf_data_in, done, flag_z, flag_n, flag_v},
                  32'd0);
        check_val("reset_result", {16'd0, result}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_cmd(2'd0, 3'(i), 3'd0, 3'd0, 16'($urandom), 2'd0);

        run_cmd(2'd0, 3'd3, 3'd0, 3'd0, 16'h1234, 2'd0);
        run_cmd(2'd0, 3'd1, 3'd0, 3'd0, 16'd5, 2'd0);
        run_cmd(2'd0, 3'd2, 3'd0, 3'd0, 16'd7, 2'd0);
        run_cmd(2'd2, 3'd0, 3'd1, 3'd2, 16'd0, 2'd0);
        run_cmd(2'd0, 3'd4, 3'd0, 3'd0, 16'h7FFF, 2'd0);
        run_cmd(2'd0, 3'd5, 3'd0, 3'd0, 16'h0001, 2'd0);
        run_cmd(2'd3, 3'd0, 3'd5, 3'd4, 16'd0, 2'd0);
        run_cmd(2'd0, 3'd6, 3'd0, 3'd0, 16'h8000, 2'd0);
        run_cmd(2'd3, 3'd0, 3'd6, 3'd5, 16'd0, 2'd0);
        run_cmd(2'd0, 3'd1, 3'd0, 3'd0, 16'h0003, 2'd0);
        run_cmd(2'd2, 3'd1, 3'd1, 3'd1, 16'd0, 2'd0);
        run_cmd(2'd1, 3'd7, 3'd0, 3'd1, 16'd0, 2'd0);
`ifdef RF_CMD_SHIFT_EN
        run_cmd(2'd0, 3'd2, 3'd0, 3'd0, 16'h8001, 2'd0);
        run_cmd(2'd1, 3'd3, 3'd0, 3'd2, 16'd0, 2'd3);
        run_cmd(2'd1, 3'd3, 3'd0, 3'd2, 16'd0, 2'd1);
        run_cmd(2'd1, 3'd3, 3'd0, 3'd2, 16'd0, 2'd2);
`endif

        reset_mid_add(3'd0, 3'd1, 3'd2);

        for (int i = 0; i < 40; i++) begin
            sh = 2'd0;
`ifdef RF_CMD_SHIFT_EN
            sh = 2'($urandom);
`endif
            run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), sh);
        end

        for (int i = 0; i < 8; i++) check_val("final_rf", {16'd0, rf_mem[i]}, {16'd0, m_regs[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
